// File: rtl/ft2232h_tx_fifo.sv
// ft2232h_tx_fifo
// Transmit path for the FT2232H in synchronous 245 FIFO mode. Words from a
// valid/ready source are buffered in a DEPTH-word FIFO and serialised
// LSB-byte-first onto the FTDI bus under TXE#/WR# flow control, at up to one
// byte per clk. An idle timer pulses SIWU# so the FTDI flushes a partial
// packet to the host once the stream goes quiet.
//
// state   | meaning
// --------+------------------------------------------------------------
// TX_IDLE | output register empty, wr_n high, data_out holds last byte
// TX_SEND | data_out holds a byte, wr_n low, waiting for txe_n low

module ft2232h_tx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int SIWU_IDLE  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  input  logic                    txe_n,
  output logic                    wr_n,
  output logic [7:0]              data_out,
  output logic                    siwu_n,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [IW-1:0] LAST_IDX   = IW'(BYTES - 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  tx_state_t state_q;
  tx_state_t state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr_q;
  logic [AW:0]           rd_ptr_q;
  logic [AW:0]           wr_ptr_d;
  logic [AW:0]           rd_ptr_d;
  logic [AW:0]           level_d;
  logic                  s_ready_q;

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] ser_q;
  logic [IW-1:0]         idx_q;
  logic [7:0]            data_q;

  logic push;
  logic pop;
  logic shift;
  logic xfer;
  logic out_free;
  logic fifo_empty;
  logic more_bytes;

  assign push       = s_valid && s_ready_q;
  assign xfer       = (state_q == TX_SEND) && !txe_n;
  assign out_free   = (state_q == TX_IDLE) || xfer;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  // A word sits in the serialiser only while TX_SEND; the last byte is at LAST_IDX.
  assign more_bytes = (state_q == TX_SEND) && (idx_q != LAST_IDX);
  assign head       = mem[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  assign level_d  = wr_ptr_d - rd_ptr_d;

  assign s_ready  = s_ready_q;
  assign wr_n     = (state_q == TX_IDLE);
  assign data_out = data_q;
  assign level    = wr_ptr_q - rd_ptr_q;
  assign busy     = !fifo_empty || (state_q == TX_SEND);

  // Transmit state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: finish the current word first, then pull the next one from
  // the FIFO in the same cycle so back-to-back words have no bubble.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    shift   = 1'b0;
    if (out_free) begin
      if (more_bytes) begin
        shift   = 1'b1;
        state_d = TX_SEND;
      end else if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = TX_SEND;
      end else begin
        state_d = TX_IDLE;
      end
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= s_data;
    end
  end

  // FIFO pointers and registered ready (no write-through when full).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      s_ready_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      s_ready_q <= (level_d != FULL_LEVEL);
    end
  end

  // Serialiser: latch a popped word and shift it out one byte per free slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= 8'h00;
      ser_q  <= '0;
      idx_q  <= '0;
    end else if (pop) begin
      data_q <= head[7:0];
      ser_q  <= head >> 8;
      idx_q  <= '0;
    end else if (shift) begin
      data_q <= ser_q[7:0];
      ser_q  <= ser_q >> 8;
      idx_q  <= idx_q + 1'b1;
    end
  end

  generate
    if (SIWU_IDLE > 0) begin : g_siwu
      localparam int CW = $clog2(SIWU_IDLE + 1);
      localparam logic [CW-1:0] CNT_LOAD = CW'(SIWU_IDLE);
      localparam logic [CW-1:0] CNT_LAST = CW'(1);

      logic          armed_q;
      logic [CW-1:0] cnt_q;
      logic          siwu_q;

      // Idle down-counter: armed by any delivered byte, reloaded by traffic,
      // fires one low cycle on the SIWU_IDLE-th idle clock, then disarms.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          armed_q <= 1'b0;
          cnt_q   <= CNT_LOAD;
          siwu_q  <= 1'b1;
        end else begin
          siwu_q <= 1'b1;
          if (xfer) begin
            armed_q <= 1'b1;
          end
          if (push || busy) begin
            cnt_q <= CNT_LOAD;
          end else if (armed_q) begin
            if (cnt_q == CNT_LAST) begin
              siwu_q  <= 1'b0;
              armed_q <= 1'b0;
              cnt_q   <= CNT_LOAD;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
      end

      assign siwu_n = siwu_q;
    end else begin : g_no_siwu
      assign siwu_n = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_ft2232h_tx_fifo.sv
// tb_ft2232h_tx_fifo
// Directed bench for ft2232h_tx_fifo (32-bit words, DEPTH=4, SIWU_IDLE=3).
// Accepted words push their bytes into a queue; a monitor pops and compares
// on every delivered byte.

module tb_ft2232h_tx_fifo;

  localparam int DW        = 32;
  localparam int DEPTH     = 4;
  localparam int AW        = 2;
  localparam int SIWU_IDLE = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          txe_n;
  logic          wr_n;
  logic [7:0]    data_out;
  logic          siwu_n;
  logic [AW:0]   level;
  logic          busy;

  int n_checks  = 0;
  int n_fail    = 0;
  int siwu_lows = 0;
  int snap;

  logic [7:0] exp_q[$];
  logic [7:0] e_byte;

  ft2232h_tx_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .SIWU_IDLE (SIWU_IDLE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .txe_n   (txe_n),
    .wr_n    (wr_n),
    .data_out(data_out),
    .siwu_n  (siwu_n),
    .level   (level),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one word; on acceptance its bytes become expected output.
  task automatic push_word(input logic [DW-1:0] w);
    int   budget;
    logic acc;
    budget  = 0;
    s_valid = 1'b1;
    s_data  = w;
    do begin
      acc = s_ready;
      @(posedge clk); #1;
      budget++;
    end while (!acc && budget < 200);
    s_valid = 1'b0;
    if (!acc) begin
      check("push_timeout", 64'(acc), 64'd1);
    end else begin
      for (int i = 0; i < DW/8; i++) exp_q.push_back(w[8*i +: 8]);
    end
  endtask

  task automatic drain(input string name);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 500) begin
      @(posedge clk); #1;
      b++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a byte is delivered at the coming edge when wr_n and txe_n are low.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && wr_n === 1'b0 && txe_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", data_out);
      end else begin
        e_byte = exp_q.pop_front();
        check("byte", 64'(data_out), 64'(e_byte));
      end
    end
  end

  always @(negedge clk) begin
    if (siwu_n === 1'b0) siwu_lows++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held 3 clocks with s_valid high
    reset_n = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    txe_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_n",     64'(wr_n),     64'd1);
    check("rst_data_out", 64'(data_out), 64'h00);
    check("rst_siwu_n",   64'(siwu_n),   64'd1);
    check("rst_level",    64'(level),    64'd0);
    check("rst_s_ready",  64'(s_ready),  64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    reset_n = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    check("rel_s_ready", 64'(s_ready), 64'd1);

    // Single word, byte order and latency, then SIWU timing
    push_word(32'hA1B2C3D4);
    @(posedge clk); #1;
    check("lat_wr_n",  64'(wr_n),     64'd0);
    check("lat_byte0", 64'(data_out), 64'hD4);
    @(posedge clk); #1;
    check("seq_byte1", 64'(data_out), 64'hC3);
    @(posedge clk); #1;
    check("seq_byte2", 64'(data_out), 64'hB2);
    @(posedge clk); #1;
    check("seq_byte3", 64'(data_out), 64'hA1);
    @(posedge clk); #1;
    check("end_wr_n", 64'(wr_n), 64'd1);
    check("end_busy", 64'(busy), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check("siwu_pulse", 64'(siwu_n), (k == 3) ? 64'd0 : 64'd1);
    end
    snap = siwu_lows;
    repeat (20) @(posedge clk);
    #1;
    check("siwu_no_repeat", 64'(siwu_lows), 64'(snap));

    // A write during the idle count restarts it
    push_word(32'h11223344);
    repeat (5) @(posedge clk);
    #1;
    check("rs_wr_n", 64'(wr_n), 64'd1);
    repeat (2) begin
      @(posedge clk); #1;
      check("rs_pre_siwu", 64'(siwu_n), 64'd1);
    end
    push_word(32'h55667788);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check("rs_siwu", 64'(siwu_n), (k == 8) ? 64'd0 : 64'd1);
    end
    drain("drain_restart");

    // Back-to-back words with a 5-clock TXE# stall on byte0
    push_word(32'h04030201);
    txe_n = 1'b1;
    push_word(32'h08070605);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("stall_wr_n", 64'(wr_n),     64'd0);
      check("stall_byte", 64'(data_out), 64'h01);
    end
    txe_n = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      check("b2b_no_gap", 64'(wr_n), 64'd0);
    end
    @(posedge clk); #1;
    check("b2b_done", 64'(wr_n), 64'd1);
    drain("drain_b2b");

    // Full boundary: TXE# high, 6 words offered into serialiser + 4-deep FIFO
    txe_n = 1'b1;
    push_word(32'hF1F2F3F4);
    push_word(32'hE1E2E3E4);
    push_word(32'hD1D2D3D4);
    push_word(32'hC1C2C3C4);
    push_word(32'hB1B2B3B4);
    check("full_level",   64'(level),   64'd4);
    check("full_s_ready", 64'(s_ready), 64'd0);
    check("full_busy",    64'(busy),    64'd1);
    fork
      push_word(32'hA5A6A7A8);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          check("full_hold_ready", 64'(s_ready), 64'd0);
          check("full_hold_level", 64'(level),   64'd4);
        end
        txe_n = 1'b0;
      end
    join
    check("full_refill_level", 64'(level), 64'd4);
    drain("drain_full");
    check("empty_level", 64'(level), 64'd0);
    check("empty_busy",  64'(busy),  64'd0);

    // Reset after 2 of 4 bytes delivered
    repeat (6) @(posedge clk);
    #1;
    txe_n = 1'b1;
    push_word(32'h9A9B9C9D);
    @(posedge clk); #1;
    txe_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    txe_n   = 1'b1;
    @(posedge clk); #1;
    check("midrst_wr_n",     64'(wr_n),     64'd1);
    check("midrst_data_out", 64'(data_out), 64'h00);
    check("midrst_level",    64'(level),    64'd0);
    check("midrst_left",     64'(exp_q.size()), 64'd2);
    exp_q.delete();
    reset_n = 1'b1;
    txe_n   = 1'b0;
    push_word(32'h5A6B7C8D);
    @(posedge clk); #1;
    check("post_rst_wr_n",  64'(wr_n),     64'd0);
    check("post_rst_byte0", 64'(data_out), 64'h8D);
    drain("drain_post_rst");
    check("final_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
